// File: rtl/topk_result_drain_if.sv
// Bus between the bitonic sorter output, the top-K drain and the result consumer.
// The slave modport is the drain; the master modport is the sorter/consumer side.
interface topk_result_drain_if #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 8,
    parameter int K          = 4,
    parameter int FIFO_DEPTH = 2
);
    localparam int RANKW  = $clog2((K > 2) ? K : 2);
    localparam int LEVELW = $clog2(FIFO_DEPTH + 1);

    logic                 in_valid_i;
    logic                 in_sign_i;
    logic [DATAWIDTH-1:0] in_data_i [DATALENGTH-1:0];
    logic                 clear_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DATAWIDTH-1:0] out_data_o;
    logic [RANKW-1:0]     out_rank_o;
    logic                 out_last_o;
    logic [LEVELW-1:0]    level_o;
    logic                 overflow_o;

    modport slave (
        input  in_valid_i, in_sign_i, in_data_i, clear_i, out_ready_i,
        output out_valid_o, out_data_o, out_rank_o, out_last_o, level_o, overflow_o
    );

    modport master (
        output in_valid_i, in_sign_i, in_data_i, clear_i, out_ready_i,
        input  out_valid_o, out_data_o, out_rank_o, out_last_o, level_o, overflow_o
    );
endinterface

// File: rtl/topk_result_drain.sv
// Buffers sorted vectors from the bitonic sorter and streams the K largest
// elements of each one, largest first, over a valid/ready interface.
module topk_result_drain #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 8,
    parameter int K          = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    topk_result_drain_if.slave   bus
);
    localparam int RANKW  = $clog2((K > 2) ? K : 2);
    localparam int LEVELW = $clog2(FIFO_DEPTH + 1);
    localparam int PTRW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IDXW   = (DATALENGTH > 1) ? $clog2(DATALENGTH) : 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                                  state_q, state_d;
    logic [RANKW-1:0]                        rank_q, rank_d;
    logic [LEVELW-1:0]                       count_q, count_d;
    logic [PTRW-1:0]                         rdPtr_q, rdPtr_d;
    logic [PTRW-1:0]                         wrPtr_q, wrPtr_d;
    logic                                    overflow_q, overflow_d;
    logic [DATALENGTH-1:0][DATAWIDTH-1:0]    dataMem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]                   signMem_q;

    logic                                    outValid;
    logic                                    lastRank;
    logic                                    handshake;
    logic                                    pop;
    logic                                    full;
    logic                                    push;
    logic                                    drop;
    logic                                    headSign;
    logic [IDXW-1:0]                         rankIdx;
    logic [IDXW-1:0]                         headIdx;
    logic [DATALENGTH-1:0][DATAWIDTH-1:0]    headData;
    logic [DATALENGTH-1:0][DATAWIDTH-1:0]    inPacked;

    function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
        if (p == PTRW'(FIFO_DEPTH - 1)) begin
            nextPtr = '0;
        end else begin
            nextPtr = p + 1'b1;
        end
    endfunction

    always_comb begin
        for (int i = 0; i < DATALENGTH; i++) begin
            inPacked[i] = bus.in_data_i[i];
        end
    end

    // A full FIFO still accepts a strobe when the head is popped in the same cycle.
    always_comb begin
        outValid  = (state_q == EMIT);
        lastRank  = (rank_q == RANKW'(K - 1));
        handshake = outValid && bus.out_ready_i;
        pop       = handshake && lastRank;
        full      = (count_q == LEVELW'(FIFO_DEPTH));
        push      = bus.in_valid_i && (!full || pop);
        drop      = bus.in_valid_i && full && !pop;
    end

    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (push) begin
            wrPtr_d = nextPtr(wrPtr_q);
        end
        if (pop) begin
            rdPtr_d = nextPtr(rdPtr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_i) begin
            overflow_d = 1'b0;
        end
    end

    // Staying in EMIT after a pop lets the next vector follow with no bubble.
    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = EMIT;
                    rank_d  = '0;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (lastRank) begin
                        rank_d = '0;
                        if (count_d == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        rank_d = rank_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rank_d  = '0;
            end
        endcase
    end

    // Descending vectors hold the maximum at index 0, ascending ones at the top.
    always_comb begin
        headSign = signMem_q[rdPtr_q];
        headData = dataMem_q[rdPtr_q];
        rankIdx  = IDXW'(rank_q);
        headIdx  = headSign ? rankIdx : (IDXW'(DATALENGTH - 1) - rankIdx);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            rank_q     <= '0;
            count_q    <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rank_q     <= rank_d;
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dataMem_q[i] <= '0;
            end
            signMem_q <= '0;
        end else if (push) begin
            dataMem_q[wrPtr_q] <= inPacked;
            signMem_q[wrPtr_q] <= bus.in_sign_i;
        end
    end

    assign bus.out_valid_o = outValid;
    assign bus.out_data_o  = outValid ? headData[headIdx] : '0;
    assign bus.out_rank_o  = outValid ? rank_q : '0;
    assign bus.out_last_o  = outValid && lastRank;
    assign bus.level_o     = count_q;
    assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_topk_result_drain.sv
// Scoreboard bench for topk_result_drain: expected top-K elements are queued when a
// vector is strobed in and popped as the drain presents them.
module tb_topk_result_drain;
    localparam int DW = 8;
    localparam int DL = 8;
    localparam int K  = 4;
    localparam int FD = 2;

    typedef logic [DL-1:0][DW-1:0] vec_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    rank;
        logic          last;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    int   asserts = 0;
    int   fails   = 0;
    exp_t expQ[$];

    always #5 clk_i = ~clk_i;

    topk_result_drain_if #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .FIFO_DEPTH(FD)) bus ();

    topk_result_drain #(.DATAWIDTH(DW), .DATALENGTH(DL), .K(K), .FIFO_DEPTH(FD)) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic driveVector(input logic sign, input vec_t v);
        bus.in_sign_i  = sign;
        for (int i = 0; i < DL; i++) bus.in_data_i[i] = v[i];
        bus.in_valid_i = 1'b1;
    endtask

    // Reference model: sort the values largest first and keep the first K.
    task automatic pushVector(input vec_t v);
        int   vals[DL];
        int   tmp;
        exp_t e;
        for (int i = 0; i < DL; i++) vals[i] = int'(v[i]);
        for (int i = 0; i < DL; i++)
            for (int j = 0; j < DL - 1 - i; j++)
                if (vals[j] < vals[j+1]) begin
                    tmp = vals[j]; vals[j] = vals[j+1]; vals[j+1] = tmp;
                end
        for (int r = 0; r < K; r++) begin
            e.data = DW'(vals[r]);
            e.rank = 2'(r);
            e.last = (r == K - 1);
            expQ.push_back(e);
        end
    endtask

    function automatic vec_t mkVec(input int a0, a1, a2, a3, a4, a5, a6, a7);
        vec_t v;
        v[0] = DW'(a0); v[1] = DW'(a1); v[2] = DW'(a2); v[3] = DW'(a3);
        v[4] = DW'(a4); v[5] = DW'(a5); v[6] = DW'(a6); v[7] = DW'(a7);
        return v;
    endfunction

    function automatic vec_t randomSorted(input logic sign);
        int   vals[DL];
        int   tmp;
        vec_t v;
        for (int i = 0; i < DL; i++) vals[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < DL; i++)
            for (int j = 0; j < DL - 1 - i; j++)
                if (vals[j] < vals[j+1]) begin
                    tmp = vals[j]; vals[j] = vals[j+1]; vals[j+1] = tmp;
                end
        for (int i = 0; i < DL; i++) v[i] = sign ? DW'(vals[i]) : DW'(vals[DL-1-i]);
        return v;
    endfunction

    task automatic test_reset();
        rstn_i = 1'b0;
        #1;
        asserts++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %0b expected 0", bus.out_valid_o); end
        asserts++; if (bus.level_o !== 2'd0) begin fails++; $display("[TB] FAIL reset_level got %0d expected 0", bus.level_o); end
        asserts++; if (bus.overflow_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_overflow got %0b expected 0", bus.overflow_o); end
        asserts++; if (bus.out_data_o !== 8'd0) begin fails++; $display("[TB] FAIL reset_data got %0d expected 0", bus.out_data_o); end
        cycle();
        cycle();
        rstn_i = 1'b1;
        cycle();
        asserts++; if (bus.out_valid_o !== 1'b0 || bus.out_rank_o !== 2'd0 || bus.out_last_o !== 1'b0) begin
            fails++; $display("[TB] FAIL post_reset_outputs got valid=%0b rank=%0d last=%0b expected 0/0/0", bus.out_valid_o, bus.out_rank_o, bus.out_last_o);
        end
    endtask

    task automatic test_single_vector(input string name, input logic sign, input vec_t v);
        exp_t e;
        bus.out_ready_i = 1'b1;
        driveVector(sign, v);
        pushVector(v);
        cycle();
        bus.in_valid_i = 1'b0;
        asserts++; if (bus.level_o !== 2'd1) begin fails++; $display("[TB] FAIL %s level_t1 got %0d expected 1", name, bus.level_o); end
        asserts++; if (bus.out_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL %s valid_t1 got %0b expected 0", name, bus.out_valid_o); end
        cycle();
        for (int n = 0; n < K; n++) begin
            e = expQ.pop_front();
            asserts++; if (bus.out_valid_o !== 1'b1) begin fails++; $display("[TB] FAIL %s valid[%0d] got %0b expected 1", name, n, bus.out_valid_o); end
            asserts++; if (bus.out_data_o !== e.data) begin fails++; $display("[TB] FAIL %s data[%0d] got %0d expected %0d", name, n, bus.out_data_o, e.data); end
            asserts++; if (bus.out_rank_o !== e.rank || bus.out_last_o !== e.last) begin
                fails++; $display("[TB] FAIL %s rank/last[%0d] got %0d/%0b expected %0d/%0b", name, n, bus.out_rank_o, bus.out_last_o, e.rank, e.last);
            end
            cycle();
        end
        asserts++; if (bus.out_valid_o !== 1'b0 || bus.level_o !== 2'd0) begin
            fails++; $display("[TB] FAIL %s idle_after got valid=%0b level=%0d expected 0/0", name, bus.out_valid_o, bus.level_o);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.out_ready_i = 1'b1;
        driveVector(1'b1, mkVec(200, 150, 120, 100, 80, 60, 40, 20));
        pushVector(mkVec(200, 150, 120, 100, 80, 60, 40, 20));
        cycle();
        asserts++; if (bus.level_o !== 2'd1) begin fails++; $display("[TB] FAIL b2b level_first got %0d expected 1", bus.level_o); end
        driveVector(1'b0, mkVec(3, 4, 9, 11, 17, 33, 64, 250));
        pushVector(mkVec(3, 4, 9, 11, 17, 33, 64, 250));
        cycle();
        bus.in_valid_i = 1'b0;
        for (int n = 0; n < 2 * K; n++) begin
            e = expQ.pop_front();
            asserts++; if (bus.out_valid_o !== 1'b1) begin fails++; $display("[TB] FAIL b2b gap[%0d] got valid %0b expected 1", n, bus.out_valid_o); end
            asserts++; if (bus.out_data_o !== e.data || bus.out_rank_o !== e.rank || bus.out_last_o !== e.last) begin
                fails++; $display("[TB] FAIL b2b elem[%0d] got %0d/%0d/%0b expected %0d/%0d/%0b", n, bus.out_data_o, bus.out_rank_o, bus.out_last_o, e.data, e.rank, e.last);
            end
            asserts++; if (bus.level_o !== ((n < K) ? 2'd2 : 2'd1)) begin
                fails++; $display("[TB] FAIL b2b level[%0d] got %0d expected %0d", n, bus.level_o, (n < K) ? 2 : 1);
            end
            cycle();
        end
        asserts++; if (bus.out_valid_o !== 1'b0 || bus.level_o !== 2'd0) begin
            fails++; $display("[TB] FAIL b2b end got valid=%0b level=%0d expected 0/0", bus.out_valid_o, bus.level_o);
        end
    endtask

    task automatic test_overflow();
        exp_t          e;
        logic [DW-1:0] holdData;
        logic [1:0]    holdRank;
        logic          holdLast;
        bus.out_ready_i = 1'b0;
        driveVector(1'b1, mkVec(99, 88, 77, 66, 55, 44, 33, 22));
        pushVector(mkVec(99, 88, 77, 66, 55, 44, 33, 22));
        cycle();
        driveVector(1'b0, mkVec(10, 12, 14, 16, 18, 20, 22, 24));
        pushVector(mkVec(10, 12, 14, 16, 18, 20, 22, 24));
        cycle();
        asserts++; if (bus.level_o !== 2'd2) begin fails++; $display("[TB] FAIL ovf level_full got %0d expected 2", bus.level_o); end
        driveVector(1'b1, mkVec(250, 249, 248, 247, 246, 245, 244, 243));
        cycle();
        bus.in_valid_i = 1'b0;
        asserts++; if (bus.overflow_o !== 1'b1) begin fails++; $display("[TB] FAIL ovf sticky got %0b expected 1", bus.overflow_o); end
        asserts++; if (bus.level_o !== 2'd2) begin fails++; $display("[TB] FAIL ovf level_after_drop got %0d expected 2", bus.level_o); end
        holdData = bus.out_data_o; holdRank = bus.out_rank_o; holdLast = bus.out_last_o;
        asserts++; if (holdData !== expQ[0].data) begin fails++; $display("[TB] FAIL ovf stall_head got %0d expected %0d", holdData, expQ[0].data); end
        for (int c = 0; c < 3; c++) begin
            cycle();
            asserts++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== holdData || bus.out_rank_o !== holdRank || bus.out_last_o !== holdLast) begin
                fails++; $display("[TB] FAIL ovf stall_hold[%0d] got %0b/%0d/%0d/%0b expected 1/%0d/%0d/%0b", c, bus.out_valid_o, bus.out_data_o, bus.out_rank_o, bus.out_last_o, holdData, holdRank, holdLast);
            end
        end
        bus.clear_i = 1'b1;
        cycle();
        bus.clear_i = 1'b0;
        asserts++; if (bus.overflow_o !== 1'b0) begin fails++; $display("[TB] FAIL ovf clear got %0b expected 0", bus.overflow_o); end
        driveVector(1'b1, mkVec(250, 249, 248, 247, 246, 245, 244, 243));
        bus.clear_i = 1'b1;
        cycle();
        bus.in_valid_i = 1'b0;
        bus.clear_i    = 1'b0;
        asserts++; if (bus.overflow_o !== 1'b1) begin fails++; $display("[TB] FAIL ovf drop_beats_clear got %0b expected 1", bus.overflow_o); end
        bus.clear_i = 1'b1;
        cycle();
        bus.clear_i = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int n = 0; n < 2 * K; n++) begin
            e = expQ.pop_front();
            asserts++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data || bus.out_rank_o !== e.rank || bus.out_last_o !== e.last) begin
                fails++; $display("[TB] FAIL ovf drain[%0d] got %0b/%0d/%0d/%0b expected 1/%0d/%0d/%0b", n, bus.out_valid_o, bus.out_data_o, bus.out_rank_o, bus.out_last_o, e.data, e.rank, e.last);
            end
            cycle();
        end
        for (int c = 0; c < 3; c++) begin
            asserts++; if (bus.out_valid_o !== 1'b0 || bus.level_o !== 2'd0 || bus.overflow_o !== 1'b0) begin
                fails++; $display("[TB] FAIL ovf dropped_emitted[%0d] got valid=%0b level=%0d ovf=%0b expected 0/0/0", c, bus.out_valid_o, bus.level_o, bus.overflow_o);
            end
            cycle();
        end
    endtask

    task automatic test_full_with_pop();
        exp_t e;
        bit   injected = 0;
        int   n = 0;
        bus.out_ready_i = 1'b0;
        driveVector(1'b1, mkVec(140, 130, 120, 110, 100, 90, 80, 70));
        pushVector(mkVec(140, 130, 120, 110, 100, 90, 80, 70));
        cycle();
        driveVector(1'b1, mkVec(60, 50, 45, 40, 35, 30, 25, 2));
        pushVector(mkVec(60, 50, 45, 40, 35, 30, 25, 2));
        cycle();
        bus.in_valid_i = 1'b0;
        cycle();
        asserts++; if (bus.level_o !== 2'd2) begin fails++; $display("[TB] FAIL fullpop level_full got %0d expected 2", bus.level_o); end
        bus.out_ready_i = 1'b1;
        while (expQ.size() > 0 && n < 20) begin
            e = expQ.pop_front();
            asserts++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== e.data || bus.out_rank_o !== e.rank || bus.out_last_o !== e.last) begin
                fails++; $display("[TB] FAIL fullpop elem[%0d] got %0b/%0d/%0d/%0b expected 1/%0d/%0d/%0b", n, bus.out_valid_o, bus.out_data_o, bus.out_rank_o, bus.out_last_o, e.data, e.rank, e.last);
            end
            if (e.last && !injected) begin
                injected = 1;
                driveVector(1'b0, mkVec(1, 2, 3, 4, 5, 6, 7, 8));
                pushVector(mkVec(1, 2, 3, 4, 5, 6, 7, 8));
                cycle();
                bus.in_valid_i = 1'b0;
                asserts++; if (bus.level_o !== 2'd2 || bus.overflow_o !== 1'b0) begin
                    fails++; $display("[TB] FAIL fullpop accept got level=%0d ovf=%0b expected 2/0", bus.level_o, bus.overflow_o);
                end
            end else begin
                cycle();
            end
            n++;
        end
        asserts++; if (n !== 3 * K || bus.out_valid_o !== 1'b0 || bus.level_o !== 2'd0) begin
            fails++; $display("[TB] FAIL fullpop end got count=%0d valid=%0b level=%0d expected %0d/0/0", n, bus.out_valid_o, bus.level_o, 3 * K);
        end
    endtask

    task automatic test_reset_mid_emit();
        exp_t          e;
        vec_t          v;
        logic          s;
        int            consumed = 0;
        bit            havePrev = 0;
        logic [DW-1:0] prevData;
        logic [1:0]    prevRank;
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s = 1'($urandom_range(0, 1));
            v = randomSorted(s);
            driveVector(s, v);
            pushVector(v);
            cycle();
        end
        bus.in_valid_i = 1'b0;
        for (int c = 0; c < 300 && consumed < 5; c++) begin
            bus.out_ready_i = 1'($urandom_range(0, 1));
            if (bus.out_valid_o === 1'b1) begin
                e = expQ[0];
                asserts++; if (bus.out_data_o !== e.data || bus.out_rank_o !== e.rank || bus.out_last_o !== e.last) begin
                    fails++; $display("[TB] FAIL rand elem[%0d] got %0d/%0d/%0b expected %0d/%0d/%0b", consumed, bus.out_data_o, bus.out_rank_o, bus.out_last_o, e.data, e.rank, e.last);
                end
                if (havePrev) begin
                    asserts++; if (bus.out_data_o !== prevData || bus.out_rank_o !== prevRank) begin
                        fails++; $display("[TB] FAIL rand stall got %0d/%0d expected %0d/%0d", bus.out_data_o, bus.out_rank_o, prevData, prevRank);
                    end
                end
                if (bus.out_ready_i) begin
                    void'(expQ.pop_front());
                    consumed++;
                    havePrev = 0;
                end else begin
                    prevData = bus.out_data_o;
                    prevRank = bus.out_rank_o;
                    havePrev = 1;
                end
            end
            cycle();
        end
        asserts++; if (consumed < 5 || bus.out_valid_o !== 1'b1) begin
            fails++; $display("[TB] FAIL rand progress got consumed=%0d valid=%0b expected 5/1", consumed, bus.out_valid_o);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        asserts++; if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 8'd0 || bus.out_rank_o !== 2'd0 || bus.out_last_o !== 1'b0 || bus.level_o !== 2'd0) begin
            fails++; $display("[TB] FAIL midreset outputs got %0b/%0d/%0d/%0b level=%0d expected 0/0/0/0 level=0", bus.out_valid_o, bus.out_data_o, bus.out_rank_o, bus.out_last_o, bus.level_o);
        end
        expQ.delete();
        cycle();
        rstn_i = 1'b1;
        bus.out_ready_i = 1'b1;
        cycle();
        asserts++; if (bus.out_valid_o !== 1'b0 || bus.level_o !== 2'd0) begin
            fails++; $display("[TB] FAIL midreset released got valid=%0b level=%0d expected 0/0", bus.out_valid_o, bus.level_o);
        end
        test_single_vector("after_reset", 1'b1, mkVec(77, 66, 55, 44, 33, 22, 11, 0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the bench finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_sign_i   = 1'b0;
        bus.clear_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < DL; i++) bus.in_data_i[i] = '0;
        test_reset();
        test_single_vector("descending", 1'b1, mkVec(90, 70, 50, 30, 20, 10, 5, 1));
        test_single_vector("ascending", 1'b0, mkVec(1, 5, 10, 20, 30, 50, 70, 90));
        test_back_to_back();
        test_overflow();
        test_full_with_pop();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
